spi_word_peripheral: RTL and testbench

SPI_WORD_PERIPHERAL -- requirements
Module: spi_word_peripheral

---
 rtl/spi_word_peripheral.sv | 145 ++++++++++++++
 tb/tb_spi_word_peripheral.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_peripheral.sv
// SPI mode-0 peripheral that assembles WORD_BYTES-byte words from COPI and returns word_tx on CIPO.
// Optional macro SPI_WORD_OVERRUN_EN builds the sticky overrun flag; otherwise overrun is tied to 0.
module spi_word_peripheral #(
    parameter int WORD_BYTES  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    SCK,
    input  logic                    CS,
    input  logic                    COPI,
    output logic                    CIPO,
    output logic [8*WORD_BYTES-1:0] word_rx,
    output logic                    word_rx_valid,
    input  logic                    word_rx_ack,
    input  logic [8*WORD_BYTES-1:0] word_tx,
    output logic                    word_tx_taken,
    output logic                    overrun
);
    localparam int W    = 8 * WORD_BYTES;
    localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(WORD_BYTES - 1);

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, copi_sync;
    logic sck_d, cs_d;

    // NOTE: synchronous reset loads the idle bus levels, so a controller already holding CS low
    // shows up as a fresh CS fall once reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            copi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s, cs_s, copi_s, cs_low, sck_rise, sck_fall, cs_fall;
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign copi_s   = copi_sync[SYNC_STAGES-1];
    assign cs_low   = ~cs_s;
    assign sck_rise = cs_low & sck_s & ~sck_d;
    assign sck_fall = cs_low & ~sck_s & sck_d;
    assign cs_fall  = cs_low & cs_d;

    logic [2:0]      bit_cnt;
    logic [BC_W-1:0] byte_cnt;
    logic [6:0]      rx_byte;
    logic [W-1:0]    rx_acc;
    logic [7:0]      new_byte;
    logic            word_done;
    logic [W-1:0]    word_next;

    assign new_byte  = {rx_byte, copi_s};
    assign word_done = sck_rise && (bit_cnt == 3'd7) && (byte_cnt == LAST_BYTE);

    // NOTE: every always_comb output gets a full default first so no latch can be inferred.
    always_comb begin
        word_next            = rx_acc;
        word_next[W-1 -: 8]  = new_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            rx_byte       <= '0;
            rx_acc        <= '0;
            word_rx       <= '0;
            word_rx_valid <= 1'b0;
            word_tx_taken <= 1'b0;
        end else begin
            // A CS rise mid-word simply drops the partial word via the counter clear.
            if (!cs_low) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_byte <= {rx_byte[5:0], copi_s};
                if (bit_cnt == 3'd7) begin
                    rx_acc[{byte_cnt, 3'b000} +: 8] <= new_byte;
                    byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BC_W'(1);
                end
            end

            if (word_done) begin
                word_rx       <= word_next;
                word_rx_valid <= 1'b1;
            end else if (word_rx_ack) begin
                word_rx_valid <= 1'b0;
            end

            word_tx_taken <= cs_fall | word_done;
        end
    end

    logic [W-1:0] tx_shift;
    logic [2:0]   tx_fall_cnt;
    logic         tx_skip;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift    <= '0;
            tx_fall_cnt <= '0;
            tx_skip     <= 1'b0;
        end else if (cs_fall || word_done) begin
            tx_shift    <= word_tx;
            tx_fall_cnt <= '0;
            tx_skip     <= word_done;
        end else if (sck_fall) begin
            // The fall right after a word-boundary reload still belongs to the finished word.
            if (tx_skip) begin
                tx_skip <= 1'b0;
            end else begin
                tx_fall_cnt <= tx_fall_cnt + 3'd1;
                if (tx_fall_cnt == 3'd7)
                    tx_shift <= tx_shift >> 8;
                else
                    tx_shift[7:0] <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    assign CIPO = cs_low & tx_shift[7];

`ifdef SPI_WORD_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset)
            overrun <= 1'b0;
        else if (word_done && word_rx_valid && !word_rx_ack)
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_peripheral.sv
// Directed bench for spi_word_peripheral: reception, back-to-back, transmit, abort, overrun, reset.
// Overrun expectation follows SPI_WORD_OVERRUN_EN.
module tb_spi_word_peripheral;
    localparam int WB = 8;
    localparam int W  = 8 * WB;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         SCK, CS, COPI, CIPO;
    logic [W-1:0] word_rx, word_tx;
    logic         word_rx_valid, word_rx_ack, word_tx_taken, overrun;

    spi_word_peripheral #(.WORD_BYTES(WB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .SCK(SCK), .CS(CS), .COPI(COPI), .CIPO(CIPO),
        .word_rx(word_rx), .word_rx_valid(word_rx_valid), .word_rx_ack(word_rx_ack),
        .word_tx(word_tx), .word_tx_taken(word_tx_taken), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_rises = 0;
    int taken_pulses = 0;
    logic valid_q = 1'b0;
    logic [W-1:0] cap;

`ifdef SPI_WORD_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    always @(negedge clk) begin
        valid_q <= word_rx_valid;
        if (word_rx_valid && !valid_q) valid_rises <= valid_rises + 1;
        if (word_tx_taken) taken_pulses <= taken_pulses + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 controller: bit i is byte i/8, MSB first; CIPO is captured just before each rise.
    task automatic send_bits(input logic [W-1:0] w, input int first, input int count, input int hp);
        for (int i = first; i < first + count; i++) begin
            int idx;
            idx = (i / 8) * 8 + (7 - (i % 8));
            COPI = w[idx];
            tick(hp);
            cap[idx] = CIPO;
            SCK = 1'b1;
            tick(hp);
            SCK = 1'b0;
        end
    endtask

    task automatic cs_start();
        CS = 1'b0;
        tick(8);
    endtask

    task automatic cs_stop();
        tick(4);
        CS = 1'b1;
        tick(8);
    endtask

    task automatic ack_pulse();
        word_rx_ack = 1'b1;
        tick(1);
        word_rx_ack = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; SCK = 1'b0; CS = 1'b1; COPI = 1'b0; word_rx_ack = 1'b0; word_tx = '0;
        tick(3);
        @(negedge clk);
        n_cmp++; if (word_rx !== '0) begin n_bad++; $display("FAIL reset_word_rx: got %h want 0", word_rx); end
        n_cmp++; if (word_rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", word_rx_valid); end
        n_cmp++; if (word_tx_taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %b want 0", word_tx_taken); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (CIPO !== 1'b0) begin n_bad++; $display("FAIL reset_cipo: got %b want 0", CIPO); end
        tick(1);
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_single_word();
        logic [W-1:0] w;
        int lat;
        w = 64'h0a00000000000001;
        cs_start();
        send_bits(w, 0, 63, 2);
        COPI = w[56];
        tick(2);
        SCK = 1'b1;
        lat = 0;
        while (!word_rx_valid && lat < 20) begin
            tick(1);
            lat++;
        end
        n_cmp++; if (lat !== SS + 1) begin n_bad++; $display("FAIL single_valid_latency: got %0d cycles want %0d", lat, SS + 1); end
        tick(2);
        SCK = 1'b0;
        cs_stop();
        n_cmp++; if (word_rx !== w) begin n_bad++; $display("FAIL single_word_rx: got %h want %h", word_rx, w); end
        n_cmp++; if (word_rx_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid_hold: got %b want 1", word_rx_valid); end
        ack_pulse();
        n_cmp++; if (word_rx_valid !== 1'b0) begin n_bad++; $display("FAIL single_ack_clear: got %b want 0", word_rx_valid); end
        word_rx_ack = 1'b1;
        tick(3);
        word_rx_ack = 1'b0;
        tick(1);
        n_cmp++; if (word_rx_valid !== 1'b0 || word_rx !== w) begin
            n_bad++; $display("FAIL single_idle_ack: got valid=%b rx=%h want valid=0 rx=%h", word_rx_valid, word_rx, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int r0;
        a = 64'h0100000000000001;
        b = 64'h00000000005fffff;
        r0 = valid_rises;
        cs_start();
        send_bits(a, 0, 64, 2);
        tick(6);
        n_cmp++; if (word_rx !== a || word_rx_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first: got rx=%h valid=%b want rx=%h valid=1", word_rx, word_rx_valid, a);
        end
        ack_pulse();
        send_bits(b, 0, 64, 2);
        tick(6);
        n_cmp++; if (word_rx !== b || word_rx_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_second: got rx=%h valid=%b want rx=%h valid=1", word_rx, word_rx_valid, b);
        end
        ack_pulse();
        cs_stop();
        n_cmp++; if (valid_rises - r0 !== 2) begin n_bad++; $display("FAIL b2b_valid_count: got %0d want 2", valid_rises - r0); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_transmit();
        int t0;
        word_tx = 64'h1122334455667788;
        t0 = taken_pulses;
        tick(2);
        cs_start();
        n_cmp++; if (taken_pulses - t0 !== 1) begin n_bad++; $display("FAIL tx_taken_csfall: got %0d want 1", taken_pulses - t0); end
        word_tx = 64'hA5A5A5A5A5A5A5A5;
        cap = '0;
        send_bits('0, 0, 64, 6);
        tick(6);
        n_cmp++; if (cap !== 64'h1122334455667788) begin n_bad++; $display("FAIL tx_stream: got %h want 1122334455667788", cap); end
        n_cmp++; if (taken_pulses - t0 !== 2) begin n_bad++; $display("FAIL tx_taken_done: got %0d want 2", taken_pulses - t0); end
        cs_stop();
        n_cmp++; if (CIPO !== 1'b0) begin n_bad++; $display("FAIL tx_cipo_idle: got %b want 0", CIPO); end
        ack_pulse();
    endtask

    task automatic test_abort();
        int r0;
        r0 = valid_rises;
        cs_start();
        send_bits({W{1'b1}}, 0, 20, 2);
        cs_stop();
        cs_start();
        send_bits(64'h00000000000000FF, 0, 64, 2);
        cs_stop();
        n_cmp++; if (valid_rises - r0 !== 1) begin n_bad++; $display("FAIL abort_valid_count: got %0d want 1", valid_rises - r0); end
        n_cmp++; if (word_rx !== 64'h00000000000000FF) begin n_bad++; $display("FAIL abort_word_rx: got %h want 00000000000000ff", word_rx); end
        ack_pulse();
    endtask

    task automatic test_overrun();
        cs_start();
        send_bits(64'h1111111111111111, 0, 64, 2);
        send_bits(64'h2222222222222222, 0, 64, 2);
        cs_stop();
        n_cmp++; if (word_rx !== 64'h2222222222222222 || word_rx_valid !== 1'b1) begin
            n_bad++; $display("FAIL ovr_word_rx: got rx=%h valid=%b want rx=2222222222222222 valid=1", word_rx, word_rx_valid);
        end
        n_cmp++; if (overrun !== EXP_OVR) begin n_bad++; $display("FAIL ovr_flag: got %b want %b", overrun, EXP_OVR); end
        ack_pulse();
        n_cmp++; if (overrun !== EXP_OVR) begin n_bad++; $display("FAIL ovr_sticky: got %b want %b", overrun, EXP_OVR); end
    endtask

    task automatic test_reset_midword();
        logic [W-1:0] w;
        w = 64'h0a00000000000001;
        cs_start();
        send_bits({W{1'b1}}, 0, 30, 2);
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        n_cmp++; if (word_rx !== '0 || word_rx_valid !== 1'b0 || word_tx_taken !== 1'b0 || overrun !== 1'b0 || CIPO !== 1'b0) begin
            n_bad++; $display("FAIL midreset_outputs: got rx=%h valid=%b taken=%b ovr=%b cipo=%b want all 0",
                              word_rx, word_rx_valid, word_tx_taken, overrun, CIPO);
        end
        tick(1);
        reset = 1'b0;
        CS = 1'b1;
        tick(8);
        cs_start();
        send_bits(w, 0, 64, 2);
        cs_stop();
        n_cmp++; if (word_rx !== w || word_rx_valid !== 1'b1) begin
            n_bad++; $display("FAIL midreset_resume: got rx=%h valid=%b want rx=%h valid=1", word_rx, word_rx_valid, w);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_transmit();
        test_abort();
        test_overrun();
        test_reset_midword();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
